midi_note_receiver: RTL and testbench

//  Receive-side MIDI channel-voice parser. Consumes bytes from the UART RX and decodes

---
 rtl/midi_pkg.sv | 17 +
 rtl/midi_status_decode.sv | 23 ++
 rtl/midi_note_receiver.sv | 123 ++++++++++++
 tb/tb_midi_note_receiver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: MIDI parser states, status constants and message length helper
package midi_pkg;

    typedef enum logic [2:0] {IDLE, D1, D2, SKIP1, SKIP2, SKIP2B, SYSEX} state_t;

    localparam logic [3:0] NOTE_OFF    = 4'h8;
    localparam logic [3:0] NOTE_ON     = 4'h9;
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    // Number of data bytes following a channel-voice status; 0 for anything else
    function automatic logic [1:0] data_len(input logic [7:0] status);
        return (status[7:4] == 4'hC || status[7:4] == 4'hD) ? 2'd1 :
               (status[7] && status < SYSEX_START)          ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/midi_status_decode.sv
// midi_status_decode: classifies a received byte as real-time, system-common or channel-voice status
module midi_status_decode
    import midi_pkg::*;
(
    input  logic [7:0] status,
    input  logic [3:0] channel,
    input  logic       omni,
    output logic       is_realtime,
    output logic       is_syscommon,
    output logic       is_voice,
    output logic       is_note,
    output logic       chan_ok,
    output logic [1:0] data_len
);

    assign is_realtime  = status >= RT_MIN;
    assign is_syscommon = status >= SYSEX_START && !is_realtime;
    assign is_voice     = status[7] && status < SYSEX_START;
    assign is_note      = is_voice && (status[7:4] == NOTE_OFF || status[7:4] == NOTE_ON);
    assign chan_ok      = omni || status[3:0] == channel;
    assign data_len     = midi_pkg::data_len(status);

endmodule

// File: rtl/midi_note_receiver.sv
// midi_note_receiver: parses Note On/Off (with running status) from UART bytes into gate and event pulses
module midi_note_receiver
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic       note_on_pulse,
    output logic       note_off_pulse,
    output logic [6:0] ev_note,
    output logic [6:0] ev_velocity,
    output logic [3:0] ev_channel,
    output logic       gate,
    output logic [6:0] gate_note,
    output logic       drop_pulse
);

    state_t     state, state_d;
    logic [7:0] rs, rs_d;
    logic [6:0] note_q, note_d;
    logic       fire, drop_d, is_on;
    logic       is_realtime, is_syscommon, is_voice, is_note, chan_ok;
    logic [1:0] len;

    midi_status_decode u_decode (
        .status      (rx_byte),
        .channel     (CHANNEL),
        .omni        (OMNI),
        .is_realtime (is_realtime),
        .is_syscommon(is_syscommon),
        .is_voice    (is_voice),
        .is_note     (is_note),
        .chan_ok     (chan_ok),
        .data_len    (len)
    );

    assign is_on = rs[7:4] == NOTE_ON && rx_byte[6:0] != 7'd0;

    // Next-state: error aborts, real-time bytes pass through untouched, status bytes reclassify, data bytes advance
    always_comb begin
        state_d = state;
        rs_d    = rs;
        note_d  = note_q;
        fire    = 1'b0;
        drop_d  = 1'b0;
        if (rx_error) begin
            drop_d  = 1'b1;
            state_d = IDLE;
            rs_d    = 8'h00;
        end else if (rx_valid && !is_realtime) begin
            if (is_syscommon) begin
                rs_d    = 8'h00;
                state_d = rx_byte == SYSEX_START ? SYSEX : IDLE;
            end else if (is_voice) begin
                rs_d    = rx_byte;
                state_d = (is_note && chan_ok) ? D1 : (len == 2'd1) ? SKIP1 : SKIP2;
            end else begin
                case (state)
                    IDLE:    drop_d = 1'b1;
                    D1: begin
                        note_d  = rx_byte[6:0];
                        state_d = D2;
                    end
                    D2: begin
                        fire    = 1'b1;
                        state_d = D1;
                    end
                    SKIP2:   state_d = SKIP2B;
                    SKIP2B:  state_d = SKIP2;
                    default: state_d = state;
                endcase
            end
        end
    end

    // Parser state, running status and pending note number
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rs     <= 8'h00;
            note_q <= 7'd0;
        end else begin
            state  <= state_d;
            rs     <= rs_d;
            note_q <= note_d;
        end
    end

    // Event outputs and monophonic gate; a Note Off only releases the gate for the note that owns it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_on_pulse  <= 1'b0;
            note_off_pulse <= 1'b0;
            drop_pulse     <= 1'b0;
            ev_note        <= 7'd0;
            ev_velocity    <= 7'd0;
            ev_channel     <= 4'd0;
            gate           <= 1'b0;
            gate_note      <= 7'd0;
        end else begin
            note_on_pulse  <= fire && is_on;
            note_off_pulse <= fire && !is_on;
            drop_pulse     <= drop_d;
            if (fire) begin
                ev_note     <= note_q;
                ev_velocity <= rx_byte[6:0];
                ev_channel  <= rs[3:0];
                if (is_on) begin
                    gate      <= 1'b1;
                    gate_note <= note_q;
                end else if (gate_note == note_q) begin
                    gate <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_note_receiver.sv
// tb_midi_note_receiver: vector table, corner sequences and random bytes against a message-level model
module tb_midi_note_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;

    logic       on_p [2];
    logic       off_p [2];
    logic       drop_p [2];
    logic       gate_o [2];
    logic [6:0] evn [2];
    logic [6:0] evv [2];
    logic [6:0] gn [2];
    logic [3:0] evc [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    midi_note_receiver #(.CHANNEL(4'd0), .OMNI(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_error(rx_error),
        .note_on_pulse(on_p[0]), .note_off_pulse(off_p[0]), .ev_note(evn[0]), .ev_velocity(evv[0]),
        .ev_channel(evc[0]), .gate(gate_o[0]), .gate_note(gn[0]), .drop_pulse(drop_p[0])
    );

    midi_note_receiver #(.CHANNEL(4'd5), .OMNI(1'b1)) dut1 (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_error(rx_error),
        .note_on_pulse(on_p[1]), .note_off_pulse(off_p[1]), .ev_note(evn[1]), .ev_velocity(evv[1]),
        .ev_channel(evc[1]), .gate(gate_o[1]), .gate_note(gn[1]), .drop_pulse(drop_p[1])
    );

    // Message-level model: current status, collected data bytes, last event and gate owner
    logic [7:0] m_rs [2];
    logic       m_sx [2];
    int         m_n [2];
    logic [6:0] m_d [2][2];
    logic       m_on [2], m_off [2], m_drop [2], m_gate [2];
    logic [6:0] m_note [2], m_vel [2], m_gn [2];
    logic [3:0] m_ch [2];

    typedef struct {
        logic       v;
        logic       e;
        logic [7:0] b;
        logic       on, off, drop;
        logic [6:0] note, vel;
        logic       gate;
        logic [6:0] gn;
    } vec_t;
    vec_t tbl [$];

    function automatic logic [28:0] dut_vec(input int i);
        return {on_p[i], off_p[i], drop_p[i], evn[i], evv[i], evc[i], gate_o[i], gn[i]};
    endfunction

    function automatic logic [28:0] mdl_vec(input int i);
        return {m_on[i], m_off[i], m_drop[i], m_note[i], m_vel[i], m_ch[i], m_gate[i], m_gn[i]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rs[i] = 8'h00; m_sx[i] = 1'b0; m_n[i] = 0;
            m_on[i] = 1'b0; m_off[i] = 1'b0; m_drop[i] = 1'b0; m_gate[i] = 1'b0;
            m_note[i] = 7'd0; m_vel[i] = 7'd0; m_gn[i] = 7'd0; m_ch[i] = 4'd0;
        end
    endtask

    task automatic model_step(input int i, input logic v, input logic e, input logic [7:0] b);
        logic [3:0] chan;
        logic       omni;
        int         need;
        chan = (i == 0) ? 4'd0 : 4'd5;
        omni = (i == 1);
        m_on[i] = 1'b0; m_off[i] = 1'b0; m_drop[i] = 1'b0;
        if (e) begin
            m_drop[i] = 1'b1; m_rs[i] = 8'h00; m_sx[i] = 1'b0; m_n[i] = 0;
        end else if (v) begin
            if (b >= 8'hF8) begin
            end else if (b >= 8'hF0) begin
                m_rs[i] = 8'h00; m_sx[i] = (b == 8'hF0); m_n[i] = 0;
            end else if (b >= 8'h80) begin
                m_rs[i] = b; m_sx[i] = 1'b0; m_n[i] = 0;
            end else if (m_sx[i]) begin
            end else if (m_rs[i] == 8'h00) begin
                m_drop[i] = 1'b1;
            end else begin
                m_d[i][m_n[i]] = b[6:0];
                m_n[i]++;
                need = (m_rs[i][7:4] == 4'hC || m_rs[i][7:4] == 4'hD) ? 1 : 2;
                if (m_n[i] == need) begin
                    m_n[i] = 0;
                    if ((m_rs[i][7:4] == 4'h8 || m_rs[i][7:4] == 4'h9) && (omni || m_rs[i][3:0] == chan)) begin
                        m_note[i] = m_d[i][0];
                        m_vel[i]  = m_d[i][1];
                        m_ch[i]   = m_rs[i][3:0];
                        if (m_rs[i][7:4] == 4'h9 && m_vel[i] != 7'd0) begin
                            m_on[i] = 1'b1; m_gate[i] = 1'b1; m_gn[i] = m_note[i];
                        end else begin
                            m_off[i] = 1'b1;
                            if (m_gn[i] == m_note[i]) m_gate[i] = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic e, input logic [7:0] b);
        @(negedge clk);
        rx_valid = v; rx_error = e; rx_byte = b;
        @(posedge clk);
        model_step(0, v, e, b);
        model_step(1, v, e, b);
        #1;
        chk("model_ch0", {3'b0, dut_vec(0)}, {3'b0, mdl_vec(0)});
        chk("model_omni", {3'b0, dut_vec(1)}, {3'b0, mdl_vec(1)});
    endtask

    task automatic add(input logic v, input logic e, input logic [7:0] b, input logic on, input logic off,
                       input logic drop, input logic [6:0] note, input logic [6:0] vel, input logic g,
                       input logic [6:0] gnote);
        vec_t t;
        t.v = v; t.e = e; t.b = b; t.on = on; t.off = off; t.drop = drop;
        t.note = note; t.vel = vel; t.gate = g; t.gn = gnote;
        tbl.push_back(t);
    endtask

    initial begin
        // v e  byte   on off drop note   vel    gate gn
        add(1, 0, 8'h90, 0, 0, 0, 7'h00, 7'h00, 0, 7'h00);
        add(1, 0, 8'h3C, 0, 0, 0, 7'h00, 7'h00, 0, 7'h00);
        add(1, 0, 8'h64, 1, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h40, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h50, 1, 0, 0, 7'h40, 7'h50, 1, 7'h40);
        add(1, 0, 8'h90, 0, 0, 0, 7'h40, 7'h50, 1, 7'h40);
        add(1, 0, 8'h3C, 0, 0, 0, 7'h40, 7'h50, 1, 7'h40);
        add(1, 0, 8'h00, 0, 1, 0, 7'h3C, 7'h00, 1, 7'h40);
        add(1, 0, 8'h80, 0, 0, 0, 7'h3C, 7'h00, 1, 7'h40);
        add(1, 0, 8'h40, 0, 0, 0, 7'h3C, 7'h00, 1, 7'h40);
        add(1, 0, 8'h10, 0, 1, 0, 7'h40, 7'h10, 0, 7'h40);
        add(1, 0, 8'h90, 0, 0, 0, 7'h40, 7'h10, 0, 7'h40);
        add(1, 0, 8'h3C, 0, 0, 0, 7'h40, 7'h10, 0, 7'h40);
        add(1, 0, 8'hF8, 0, 0, 0, 7'h40, 7'h10, 0, 7'h40);
        add(1, 0, 8'hFE, 0, 0, 0, 7'h40, 7'h10, 0, 7'h40);
        add(1, 0, 8'h64, 1, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h91, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h3C, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h64, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'hC0, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h05, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h3C, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'hF1, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h22, 0, 0, 1, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'hF0, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h12, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h34, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h90, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h3C, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h64, 1, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h90, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h3C, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(0, 1, 8'h00, 0, 0, 1, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h64, 0, 0, 1, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h90, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h3C, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 1, 8'h64, 0, 0, 1, 7'h3C, 7'h64, 1, 7'h3C);
        add(1, 0, 8'h64, 0, 0, 1, 7'h3C, 7'h64, 1, 7'h3C);
        add(0, 0, 8'h00, 0, 0, 0, 7'h3C, 7'h64, 1, 7'h3C);

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ch0", {3'b0, dut_vec(0)}, 32'h0);
        chk("reset_omni", {3'b0, dut_vec(1)}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].e, tbl[k].b);
            chk($sformatf("vec%0d", k), {3'b0, dut_vec(0)},
                {3'b0, tbl[k].on, tbl[k].off, tbl[k].drop, tbl[k].note, tbl[k].vel, 4'd0, tbl[k].gate, tbl[k].gn});
        end

        step(1, 0, 8'h91);
        step(1, 0, 8'h3C);
        step(1, 0, 8'h64);
        chk("omni_on", {31'b0, on_p[1]}, 32'd1);
        chk("omni_chan", {28'b0, evc[1]}, 32'd1);
        chk("ch0_ignores", {31'b0, on_p[0]}, 32'd0);
        step(0, 0, 8'h00);

        step(1, 0, 8'h90);
        step(1, 0, 8'h3C);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_ch0", {3'b0, dut_vec(0)}, 32'h0);
        chk("async_rst_omni", {3'b0, dut_vec(1)}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 8'h64);
        chk("post_rst_drop", {30'b0, drop_p[0], on_p[0]}, 32'd2);

        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [7:0] b;
            logic v, e;
            r = $urandom_range(0, 99);
            v = 1'b1;
            e = ($urandom_range(0, 49) == 0);
            if (r < 45)      b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(60, 63));
            else if (r < 65) b = {($urandom_range(0, 1) == 0) ? 4'h8 : 4'h9, 4'($urandom_range(0, 2) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 1))};
            else if (r < 75) b = 8'($urandom_range(8'hA0, 8'hEF));
            else if (r < 82) b = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r < 86) b = 8'($urandom_range(8'hF0, 8'hF7));
            else begin
                v = 1'b0;
                b = 8'($urandom_range(0, 255));
            end
            step(v, e, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
